// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request op/size codes, FSM states
// and the base byte-lane enable patterns used by the lane aligner.
package lsu_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;

  localparam logic [2:0] SZ_WORD   = 3'b000;
  localparam logic [2:0] SZ_HALF_U = 3'b001;
  localparam logic [2:0] SZ_HALF_S = 3'b010;
  localparam logic [2:0] SZ_BYTE_U = 3'b011;
  localparam logic [2:0] SZ_BYTE_S = 3'b100;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// plus load lane extraction with zero/sign extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    store_data = '0;
    byte_en    = '0;
    load_data  = '0;
    lane_h     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase

    case (size)
      SZ_WORD: begin
        store_data = wdata;
        byte_en    = BE_WORD;
        load_data  = rdata;
      end
      SZ_HALF_U, SZ_HALF_S: begin
        store_data = {2{wdata[15:0]}};
        byte_en    = BE_HALF << {addr_lo[1], 1'b0};
        load_data  = (size == SZ_HALF_S) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      end
      SZ_BYTE_U, SZ_BYTE_S: begin
        store_data = {4{wdata[7:0]}};
        byte_en    = BE_BYTE << addr_lo;
        load_data  = (size == SZ_BYTE_S) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      end
      default: ;
    endcase

    // Loads leave the write side of the bus quiet
    if (!is_store) begin
      store_data = '0;
      byte_en    = '0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one access per handshake, runs a
// wait-state tolerant bus cycle and returns one response per access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              CK_REF,
  input  logic              RST_N,
  input  logic              HALT,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [2:0]        REQ_SIZE,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  input  logic [4:0]        REQ_RD,
  output logic              MEM_REQ,
  output logic              MEM_READ_WRN,
  output logic [ADDR_W-1:0] MEM_ADDRESS_BUS,
  output logic [3:0]        MEM_BYTE_EN,
  output logic [31:0]       MEM_DATA_OUT_BUS,
  input  logic [31:0]       MEM_DATA_IN_BUS,
  input  logic              MEM_ACK,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_DATA,
  output logic [4:0]        RSP_RD,
  output logic              RSP_WB,
  output logic              RSP_ERR,
  output logic              STALL
);

  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [32:0] ADDR_SPAN  = 33'd1 << ADDR_W;
  localparam logic [31:0] ADDR_MASK  = ADDR_SPAN[31:0] - 32'd1;

  logic       int_rst_n;
  lsu_state_e state, state_nxt;
  logic [7:0] wait_cnt;

  logic              accept, is_nop, req_err, misaligned, out_of_range, bad_size;
  logic              timeout, finish_access;
  logic              ld_p1;
  logic [2:0]        size_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [4:0]        rd_p1;
  logic [31:0]       rsp_data_p2;
  logic [4:0]        rsp_rd_p2;
  logic              rsp_wb_p2, rsp_err_p2;
  logic [31:0]       lane_wdata, lane_rdata;
  logic [3:0]        lane_be;

  assign int_rst_n = RST_N;

  assign is_nop       = REQ_OP[1];
  assign accept       = (state == ST_IDLE) && REQ_VALID && !HALT;
  assign bad_size     = REQ_SIZE > SZ_BYTE_S;
  assign out_of_range = |(REQ_ADDR & ~ADDR_MASK);
  assign misaligned   = ((REQ_SIZE == SZ_HALF_U || REQ_SIZE == SZ_HALF_S) && REQ_ADDR[0]) ||
                        ((REQ_SIZE == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00));
  assign req_err       = bad_size || out_of_range || misaligned;
  assign timeout       = !MEM_ACK && (wait_cnt == MAX_WAIT_C);
  assign finish_access = (state == ST_ACCESS) && (MEM_ACK || timeout);

  lsu_lane_align u_lane_align (
    .size       (size_p1),
    .addr_lo    (addr_p1[1:0]),
    .is_store   (!ld_p1),
    .wdata      (wdata_p1),
    .rdata      (MEM_DATA_IN_BUS),
    .store_data (lane_wdata),
    .byte_en    (lane_be),
    .load_data  (lane_rdata)
  );

  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_ACCESS && !MEM_ACK) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_nxt        = state;
    REQ_READY        = 1'b0;
    MEM_REQ          = 1'b0;
    MEM_READ_WRN     = 1'b1;
    MEM_ADDRESS_BUS  = '0;
    MEM_BYTE_EN      = '0;
    MEM_DATA_OUT_BUS = '0;
    RSP_VALID        = 1'b0;
    RSP_DATA         = '0;
    RSP_RD           = '0;
    RSP_WB           = 1'b0;
    RSP_ERR          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (accept && !is_nop) state_nxt = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        MEM_REQ          = 1'b1;
        MEM_READ_WRN     = ld_p1;
        MEM_ADDRESS_BUS  = {addr_p1[ADDR_W-1:2], 2'b00};
        MEM_BYTE_EN      = lane_be;
        MEM_DATA_OUT_BUS = lane_wdata;
        if (finish_access) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        RSP_VALID = !HALT;
        RSP_DATA  = rsp_data_p2;
        RSP_RD    = rsp_rd_p2;
        RSP_WB    = rsp_wb_p2;
        RSP_ERR   = rsp_err_p2;
        if (!HALT) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    STALL = !REQ_READY;
  end

  // p1: latched request; p2: response captured at error or bus completion
  always_ff @(posedge CK_REF) begin
    if (accept && !is_nop && !req_err) begin
      ld_p1    <= (REQ_OP == OP_LOAD);
      size_p1  <= REQ_SIZE;
      addr_p1  <= REQ_ADDR[ADDR_W-1:0];
      wdata_p1 <= REQ_WDATA;
      rd_p1    <= REQ_RD;
    end
    if (accept && !is_nop && req_err) begin
      rsp_data_p2 <= '0;
      rsp_rd_p2   <= REQ_RD;
      rsp_wb_p2   <= 1'b0;
      rsp_err_p2  <= 1'b1;
    end else if (finish_access) begin
      rsp_data_p2 <= (MEM_ACK && ld_p1) ? lane_rdata : 32'd0;
      rsp_rd_p2   <= rd_p1;
      rsp_wb_p2   <= MEM_ACK && ld_p1;
      rsp_err_p2  <= !MEM_ACK;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with ADDR_W=16 and MAX_WAIT=4.
module tb_load_store_unit;

  logic        CK_REF = 1'b0;
  logic        RST_N = 1'b0;
  logic        HALT = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_OP = 2'b00;
  logic [2:0]  REQ_SIZE = 3'b000;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic [4:0]  REQ_RD = '0;
  logic        MEM_REQ, MEM_READ_WRN;
  logic [15:0] MEM_ADDRESS_BUS;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_DATA_OUT_BUS;
  logic [31:0] MEM_DATA_IN_BUS = '0;
  logic        MEM_ACK = 1'b0;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic [4:0]  RSP_RD;
  logic        RSP_WB, RSP_ERR, STALL;

  int n_chk = 0;
  int n_pass = 0;

  load_store_unit #(.ADDR_W(16), .MAX_WAIT(4)) dut (
    .CK_REF(CK_REF), .RST_N(RST_N), .HALT(HALT),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_SIZE(REQ_SIZE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
    .MEM_REQ(MEM_REQ), .MEM_READ_WRN(MEM_READ_WRN), .MEM_ADDRESS_BUS(MEM_ADDRESS_BUS),
    .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_DATA_OUT_BUS(MEM_DATA_OUT_BUS),
    .MEM_DATA_IN_BUS(MEM_DATA_IN_BUS), .MEM_ACK(MEM_ACK),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_RD(RSP_RD),
    .RSP_WB(RSP_WB), .RSP_ERR(RSP_ERR), .STALL(STALL)
  );

  initial forever #5 CK_REF = ~CK_REF;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge CK_REF);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_SIZE = size;
    REQ_ADDR = addr; REQ_WDATA = wdata; REQ_RD = rd;
    tick();
    REQ_VALID = 1'b0;
  endtask

  // Access with an ack after `waits` idle cycles; checks the response cycle
  task automatic access(input string tag, input logic [1:0] op, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits,
                        input logic [15:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rsp);
    issue(op, size, addr, wdata, 5'd9);
    chk({tag, "_memreq"}, MEM_REQ, 1'b1);
    chk({tag, "_addr"}, MEM_ADDRESS_BUS, exp_addr);
    chk({tag, "_be"}, MEM_BYTE_EN, exp_be);
    chk({tag, "_wdata"}, MEM_DATA_OUT_BUS, exp_wd);
    chk({tag, "_rwn"}, MEM_READ_WRN, (op == 2'b00));
    for (int i = 0; i < waits; i++) tick();
    MEM_ACK = 1'b1; MEM_DATA_IN_BUS = rdata;
    tick();
    MEM_ACK = 1'b0; MEM_DATA_IN_BUS = '0;
    chk({tag, "_rspv"}, RSP_VALID, 1'b1);
    chk({tag, "_rspd"}, RSP_DATA, exp_rsp);
    chk({tag, "_wb"}, RSP_WB, (op == 2'b00));
    chk({tag, "_err"}, RSP_ERR, 1'b0);
    chk({tag, "_rd"}, RSP_RD, 5'd9);
    tick();
    chk({tag, "_ready"}, REQ_READY, 1'b1);
  endtask

  task automatic err_access(input string tag, input logic [2:0] size, input logic [31:0] addr);
    issue(2'b00, size, addr, 32'h0, 5'd3);
    chk({tag, "_memreq"}, MEM_REQ, 1'b0);
    chk({tag, "_rspv"}, RSP_VALID, 1'b1);
    chk({tag, "_err"}, RSP_ERR, 1'b1);
    chk({tag, "_wb"}, RSP_WB, 1'b0);
    chk({tag, "_rspd"}, RSP_DATA, 32'h0);
    tick();
    chk({tag, "_ready"}, REQ_READY, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_ready", REQ_READY, 1'b1);
    chk("rst_stall", STALL, 1'b0);
    chk("rst_memreq", MEM_REQ, 1'b0);
    chk("rst_rwn", MEM_READ_WRN, 1'b1);
    chk("rst_rspv", RSP_VALID, 1'b0);
    chk("rst_be", MEM_BYTE_EN, 4'h0);
    chk("rst_addr", MEM_ADDRESS_BUS, 16'h0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Word store, ack in cycle 1, response in cycle 2
    issue(2'b01, 3'b000, 32'h0000_0104, 32'hCAFE_F00D, 5'd5);
    chk("sw_memreq", MEM_REQ, 1'b1);
    chk("sw_addr", MEM_ADDRESS_BUS, 16'h0104);
    chk("sw_be", MEM_BYTE_EN, 4'b1111);
    chk("sw_rwn", MEM_READ_WRN, 1'b0);
    chk("sw_wdata", MEM_DATA_OUT_BUS, 32'hCAFE_F00D);
    chk("sw_stall", STALL, 1'b1);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    chk("sw_rspv", RSP_VALID, 1'b1);
    chk("sw_wb", RSP_WB, 1'b0);
    chk("sw_err", RSP_ERR, 1'b0);
    chk("sw_rd", RSP_RD, 5'd5);
    chk("sw_memreq_off", MEM_REQ, 1'b0);
    tick();
    chk("sw_rspv_once", RSP_VALID, 1'b0);
    chk("sw_ready", REQ_READY, 1'b1);

    // Loads and sub-word stores
    access("lb", 2'b00, 3'b100, 32'h3, 32'h0, 32'h8012_3456, 3, 16'h0000, 4'h0, 32'h0, 32'hFFFF_FF80);
    access("lbu", 2'b00, 3'b011, 32'h3, 32'h0, 32'h8012_3456, 0, 16'h0000, 4'h0, 32'h0, 32'h0000_0080);
    access("lh", 2'b00, 3'b010, 32'h22, 32'h0, 32'h8001_1234, 1, 16'h0020, 4'h0, 32'h0, 32'hFFFF_8001);
    access("lhu", 2'b00, 3'b001, 32'h20, 32'h0, 32'h8001_9234, 0, 16'h0020, 4'h0, 32'h0, 32'h0000_9234);
    access("sb", 2'b01, 3'b011, 32'h42, 32'h1234_56AB, 32'h0, 0, 16'h0040, 4'b0100, 32'hABAB_ABAB, 32'h0);
    access("sh", 2'b01, 3'b010, 32'h46, 32'h1234_BEEF, 32'h0, 2, 16'h0044, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access("lw", 2'b00, 3'b000, 32'hFFFC, 32'h0, 32'h1357_9BDF, 0, 16'hFFFC, 4'h0, 32'h0, 32'h1357_9BDF);

    // Errors detected at acceptance
    err_access("mis_half", 3'b010, 32'h0000_0011);
    err_access("oor_word", 3'b000, 32'h0001_0000);
    err_access("bad_size", 3'b101, 32'h0000_0000);

    // NOP consumed silently
    issue(2'b10, 3'b000, 32'h0, 32'h0, 5'd1);
    chk("nop_memreq", MEM_REQ, 1'b0);
    chk("nop_rspv", RSP_VALID, 1'b0);
    chk("nop_ready", REQ_READY, 1'b1);

    // Ack outside ACCESS is ignored
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    chk("stray_ack_rspv", RSP_VALID, 1'b0);

    // Timeout with MAX_WAIT=4
    issue(2'b00, 3'b000, 32'h20, 32'h0, 5'd4);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("to_memreq_c%0d", c), MEM_REQ, 1'b1);
      chk($sformatf("to_rspv_c%0d", c), RSP_VALID, 1'b0);
      tick();
    end
    chk("to_memreq_c6", MEM_REQ, 1'b0);
    chk("to_rspv", RSP_VALID, 1'b1);
    chk("to_err", RSP_ERR, 1'b1);
    chk("to_wb", RSP_WB, 1'b0);
    chk("to_ready_c6", REQ_READY, 1'b0);
    tick();
    chk("to_ready_c7", REQ_READY, 1'b1);

    // HALT: ACCESS not frozen, RESP held, acceptance blocked
    issue(2'b01, 3'b000, 32'h10, 32'h1, 5'd6);
    HALT = 1'b1;
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("halt_rspv_%0d", c), RSP_VALID, 1'b0);
      chk($sformatf("halt_stall_%0d", c), STALL, 1'b1);
      if (c < 2) tick();
    end
    HALT = 1'b0;
    #1;
    chk("halt_release_rspv", RSP_VALID, 1'b1);
    tick();
    chk("halt_pulse_once", RSP_VALID, 1'b0);
    HALT = 1'b1;
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_SIZE = 3'b000; REQ_ADDR = 32'h8;
    tick();
    chk("halt_noaccept_memreq", MEM_REQ, 1'b0);
    chk("halt_noaccept_ready", REQ_READY, 1'b1);
    REQ_VALID = 1'b0;
    HALT = 1'b0;
    tick();

    // Asynchronous reset during a load
    issue(2'b00, 3'b000, 32'h30, 32'h0, 5'd8);
    tick();
    chk("rstmid_memreq_before", MEM_REQ, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rstmid_memreq_async", MEM_REQ, 1'b0);
    chk("rstmid_rwn", MEM_READ_WRN, 1'b1);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    RST_N = 1'b1;
    tick();
    chk("rstmid_rspv", RSP_VALID, 1'b0);
    chk("rstmid_ready", REQ_READY, 1'b1);
    tick();
    chk("rstmid_rspv2", RSP_VALID, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
